// File: rtl/ser_pkg.sv
// Shared types and helpers for the serial nibble collector.
// The collector's optional even-parity frame check is selected with SER_PARITY_EN.
package ser_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } ser_state_t;

  // Bits on the serial line per word: data bits plus an optional parity bit.
  function automatic int frame_len(input int width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// WIDTH-bit serial-in shift register with enable, synchronous clear and selectable bit order.
// q_next is the value the register takes this edge when neither reset nor clear is active.
module ser_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {q[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
      assign shifted = {bit_in, q[WIDTH-1:1]};
    end
  endgenerate

  assign q_next = en ? shifted : q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/serial_nibble_collector.sv
// Collects a serial bit stream into WIDTH-bit words behind a valid/ready output slot.
// Define SER_PARITY_EN to append an even-parity bit to each frame and drop bad frames.
module serial_nibble_collector
  import ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             ser_valid,
  input  logic             ser_bit,
  output logic             ser_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SER_PARITY_EN
  ,
  output logic             par_err
`endif
);

`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = frame_len(WIDTH, PAR);
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  ser_state_t       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_q, shift_next, word, load_word;
  logic             accept, xfer, last_bit, word_ok, load, shift_en;

  assign ser_ready = nrst && (state == FILL);
  assign accept    = ser_valid && ser_ready;
  assign xfer      = out_valid && out_ready;
  assign last_bit  = accept && !flush && (bit_cnt == LAST_CNT);

`ifdef SER_PARITY_EN
  logic par_acc;

  // The parity bit is checked, never shifted, so the register already holds the word.
  assign shift_en = accept && !flush && (bit_cnt != LAST_CNT);
  assign word_ok  = ~(par_acc ^ ser_bit);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      par_acc <= 1'b0;
      par_err <= 1'b0;
    end else begin
      par_err <= last_bit && !word_ok;
      if (flush || last_bit) begin
        par_acc <= 1'b0;
      end else if (accept) begin
        par_acc <= par_acc ^ ser_bit;
      end
    end
  end
`else
  assign shift_en = accept && !flush;
  assign word_ok  = 1'b1;
`endif

  // With the final data bit shifting this cycle, the complete word is the register's next value.
  assign word = shift_next;

  ser_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (flush),
    .en    (shift_en),
    .bit_in(ser_bit),
    .q     (shift_q),
    .q_next(shift_next)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_word = word;
    unique case (state)
      FILL: begin
        if (last_bit && word_ok) begin
          if (!out_valid || xfer) begin
            load = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_nxt = FILL;
        end else if (xfer) begin
          load      = 1'b1;
          load_word = shift_q;
          state_nxt = FILL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      bit_cnt <= '0;
    end else if (flush) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_word;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
